// File: rtl/sm_pair_sequencer.sv
// sm_pair_sequencer: pairs an operand byte stream into A/B, samples an external sign-magnitude comparator, hands off the result.
module sm_pair_sequencer #(
  parameter int CNT_W  = 8,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [7:0]       din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [7:0]       cmp_a,
  output logic [7:0]       cmp_b,
  input  logic             cmp_ageb,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_ageb,
  output logic [7:0]       res_a,
  output logic [7:0]       res_b,
  output logic [CNT_W-1:0] pair_cnt,
  output logic [CNT_W-1:0] ge_cnt
);
  localparam int WW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  typedef enum logic [1:0] {ST_A, ST_B, ST_WAIT, ST_OUT} state_t;
  state_t           state_q;
  logic [WW-1:0]    wait_q;
  logic [7:0]       cmp_a_q, cmp_b_q, res_a_q, res_b_q;
  logic             res_valid_q, res_ageb_q;
  logic [CNT_W-1:0] pair_q, ge_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_A;
      wait_q      <= '0;
      cmp_a_q     <= '0;
      cmp_b_q     <= '0;
      res_a_q     <= '0;
      res_b_q     <= '0;
      res_ageb_q  <= 1'b0;
      res_valid_q <= 1'b0;
      pair_q      <= '0;
      ge_q        <= '0;
    end else begin
      case (state_q)
        ST_A: if (din_valid) begin
          cmp_a_q <= din;
          state_q <= ST_B;
        end
        ST_B: if (din_valid) begin
          cmp_b_q <= din;
          wait_q  <= WW'(SETTLE - 1);
          state_q <= ST_WAIT;
        end
        ST_WAIT: if (wait_q == '0) begin
          res_ageb_q  <= cmp_ageb;
          res_a_q     <= cmp_a_q;
          res_b_q     <= cmp_b_q;
          res_valid_q <= 1'b1;
          state_q     <= ST_OUT;
        end else begin
          wait_q <= wait_q - WW'(1);
        end
        ST_OUT: if (res_ready) begin
          res_valid_q <= 1'b0;
          state_q     <= ST_A;
        end
        default: state_q <= ST_A;
      endcase
      // clear overrides a coincident handoff
      if (clr) begin
        pair_q <= '0;
        ge_q   <= '0;
      end else if (state_q == ST_OUT && res_ready) begin
        if (pair_q != '1) pair_q <= pair_q + CNT_W'(1);
        if (res_ageb_q && ge_q != '1) ge_q <= ge_q + CNT_W'(1);
      end
    end
  end
  assign din_ready = (state_q == ST_A) || (state_q == ST_B);
  assign cmp_a     = cmp_a_q;
  assign cmp_b     = cmp_b_q;
  assign res_valid = res_valid_q;
  assign res_ageb  = res_ageb_q;
  assign res_a     = res_a_q;
  assign res_b     = res_b_q;
  assign pair_cnt  = pair_q;
  assign ge_cnt    = ge_q;
endmodule

// File: tb/tb_sm_pair_sequencer.sv
// tb_sm_pair_sequencer: scoreboard bench; u0 uses CNT_W=8/SETTLE=1, u1 uses CNT_W=2/SETTLE=4.
module tb_sm_pair_sequencer;
  logic       clk = 1'b0;
  logic       rst [2];
  logic       clr [2];
  logic [7:0] din [2];
  logic       din_valid [2];
  logic       din_ready [2];
  logic [7:0] ca [2];
  logic [7:0] cb [2];
  logic       cag [2];
  logic       res_valid [2];
  logic       res_ready [2];
  logic       res_ageb [2];
  logic [7:0] res_a [2];
  logic [7:0] res_b [2];
  logic [7:0] pc0, gc0;
  logic [1:0] pc1, gc1;
  int vecs = 0, errs = 0;
  int ep [2], eg [2];
  logic [16:0] q0 [$];
  logic [16:0] q1 [$];

  always #5 clk = ~clk;

  sm_pair_sequencer #(.CNT_W(8), .SETTLE(1)) u0 (
    .clk(clk), .rst(rst[0]), .clr(clr[0]), .din(din[0]), .din_valid(din_valid[0]),
    .din_ready(din_ready[0]), .cmp_a(ca[0]), .cmp_b(cb[0]), .cmp_ageb(cag[0]),
    .res_valid(res_valid[0]), .res_ready(res_ready[0]), .res_ageb(res_ageb[0]),
    .res_a(res_a[0]), .res_b(res_b[0]), .pair_cnt(pc0), .ge_cnt(gc0));

  sm_pair_sequencer #(.CNT_W(2), .SETTLE(4)) u1 (
    .clk(clk), .rst(rst[1]), .clr(clr[1]), .din(din[1]), .din_valid(din_valid[1]),
    .din_ready(din_ready[1]), .cmp_a(ca[1]), .cmp_b(cb[1]), .cmp_ageb(cag[1]),
    .res_valid(res_valid[1]), .res_ready(res_ready[1]), .res_ageb(res_ageb[1]),
    .res_a(res_a[1]), .res_b(res_b[1]), .pair_cnt(pc1), .ge_cnt(gc1));

  // behavioural stand-in for the external Compare2come comparator
  function automatic logic sm_ge(logic [7:0] a, logic [7:0] b);
    int va, vb;
    va = a[7] ? -int'(a[6:0]) : int'(a[6:0]);
    vb = b[7] ? -int'(b[6:0]) : int'(b[6:0]);
    return va >= vb;
  endfunction

  always_comb begin
    cag[0] = sm_ge(ca[0], cb[0]);
    cag[1] = sm_ge(ca[1], cb[1]);
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // monitor: compares every presented result against the queue head, pops on handoff
  task automatic mon(int i);
    logic [16:0] e;
    if (rst[i] || !res_valid[i]) return;
    if ((i == 0 ? q0.size() : q1.size()) == 0) begin
      chk($sformatf("u%0d res_valid with empty scoreboard", i), 32'(res_valid[i]), 0);
      return;
    end
    e = (i == 0) ? q0[0] : q1[0];
    chk($sformatf("u%0d res_ageb", i), 32'(res_ageb[i]), 32'(e[16]));
    chk($sformatf("u%0d res_a", i), 32'(res_a[i]), 32'(e[15:8]));
    chk($sformatf("u%0d res_b", i), 32'(res_b[i]), 32'(e[7:0]));
    if (res_ready[i]) begin
      if (i == 0) void'(q0.pop_front());
      else void'(q1.pop_front());
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pcnt(int i);
    return (i == 0) ? 32'(pc0) : 32'(pc1);
  endfunction

  function automatic logic [31:0] gcnt(int i);
    return (i == 0) ? 32'(gc0) : 32'(gc1);
  endfunction

  task automatic chk_cnt(int i);
    chk($sformatf("u%0d pair_cnt", i), pcnt(i), 32'(ep[i]));
    chk($sformatf("u%0d ge_cnt", i), gcnt(i), 32'(eg[i]));
  endtask

  task automatic upd(int i, logic ag);
    int mx;
    mx = (i == 0) ? 255 : 3;
    if (ep[i] < mx) ep[i]++;
    if (ag && eg[i] < mx) eg[i]++;
  endtask

  task automatic put(int i, logic [7:0] b);
    int n;
    n = 0;
    din[i] = b;
    din_valid[i] = 1'b1;
    while (!din_ready[i] && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk($sformatf("u%0d din_ready timeout", i), 32'(din_ready[i]), 1);
    tick();
    din_valid[i] = 1'b0;
  endtask

  task automatic post(int i, logic [7:0] a, logic [7:0] b, logic ag);
    int n, settle;
    settle = (i == 0) ? 1 : 4;
    if (i == 0) q0.push_back({ag, a, b});
    else q1.push_back({ag, a, b});
    chk($sformatf("u%0d cmp_a", i), 32'(ca[i]), 32'(a));
    chk($sformatf("u%0d cmp_b", i), 32'(cb[i]), 32'(b));
    n = 1;
    while (!res_valid[i] && n < 20) begin
      chk($sformatf("u%0d din_ready during settle", i), 32'(din_ready[i]), 0);
      tick();
      n++;
    end
    chk($sformatf("u%0d B-to-res_valid edges", i), 32'(n), 32'(settle + 1));
    if (res_ready[i]) begin
      upd(i, ag);
      tick();
      chk_cnt(i);
    end
  endtask

  task automatic pair(int i, logic [7:0] a, logic [7:0] b, logic ag, int gap);
    repeat (gap) tick();
    put(i, a);
    repeat (gap) tick();
    put(i, b);
    post(i, a, b, ag);
  endtask

  task automatic clr_pulse(int i);
    clr[i] = 1'b1;
    tick();
    clr[i] = 1'b0;
    ep[i] = 0;
    eg[i] = 0;
    chk_cnt(i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; clr[i] = 1'b0; din[i] = '0; din_valid[i] = 1'b0; res_ready[i] = 1'b1;
      ep[i] = 0; eg[i] = 0;
    end
    tick();
    tick();
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d reset din_ready", i), 32'(din_ready[i]), 1);
      chk($sformatf("u%0d reset cmp", i), {16'd0, ca[i], cb[i]}, 0);
      chk($sformatf("u%0d reset res", i), {7'd0, res_valid[i], res_ageb[i], res_a[i], res_b[i]}, 0);
      chk_cnt(i);
    end
    // basic pair, back-to-back bytes
    pair(0, 8'h05, 8'h83, 1'b1, 0);
    // signed corner pairs
    clr_pulse(0);
    pair(0, 8'h81, 8'h01, 1'b0, 0);
    pair(0, 8'h80, 8'h00, 1'b1, 0);
    pair(0, 8'h7F, 8'hFF, 1'b1, 0);
    chk("u0 pair_cnt after corners", pcnt(0), 3);
    chk("u0 ge_cnt after corners", gcnt(0), 2);
    // backpressure with din_valid held high
    res_ready[0] = 1'b0;
    pair(0, 8'h40, 8'h20, 1'b1, 0);
    din[0] = 8'h11;
    din_valid[0] = 1'b1;
    repeat (5) begin
      chk("u0 din_ready under backpressure", 32'(din_ready[0]), 0);
      chk("u0 res_valid held", 32'(res_valid[0]), 1);
      chk_cnt(0);
      tick();
    end
    res_ready[0] = 1'b1;
    upd(0, 1'b1);
    tick();
    chk("u0 din_ready after handoff", 32'(din_ready[0]), 1);
    chk_cnt(0);
    tick();
    din_valid[0] = 1'b0;
    put(0, 8'h91);
    post(0, 8'h11, 8'h91, 1'b1);
    // reset mid-pair
    put(0, 8'h12);
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    ep[0] = 0;
    eg[0] = 0;
    chk("u0 cmp_a after rst", 32'(ca[0]), 0);
    chk("u0 res_valid after rst", 32'(res_valid[0]), 0);
    chk("u0 din_ready after rst", 32'(din_ready[0]), 1);
    chk_cnt(0);
    pair(0, 8'h03, 8'h03, 1'b1, 0);
    // saturation with CNT_W=2, then clear coincident with handoff
    clr_pulse(1);
    pair(1, 8'h10, 8'h05, 1'b1, 0);
    pair(1, 8'h00, 8'h80, 1'b1, 0);
    pair(1, 8'h85, 8'h86, 1'b1, 0);
    pair(1, 8'h7F, 8'h7F, 1'b1, 0);
    chk("u1 pair_cnt saturated", pcnt(1), 3);
    res_ready[1] = 1'b0;
    pair(1, 8'h01, 8'hFF, 1'b1, 0);
    clr[1] = 1'b1;
    res_ready[1] = 1'b1;
    tick();
    clr[1] = 1'b0;
    ep[1] = 0;
    eg[1] = 0;
    chk_cnt(1);
    chk("u1 din_ready after clr handoff", 32'(din_ready[1]), 1);
    // SETTLE=4 with gaps between bytes
    pair(1, 8'h20, 8'h30, 1'b0, 3);
    pair(1, 8'hA0, 8'hB0, 1'b1, 3);
    repeat (3) tick();
    chk("u0 scoreboard drained", 32'(q0.size()), 0);
    chk("u1 scoreboard drained", 32'(q1.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
